cyclic_coder_framed: RTL and testbench
======================================

CYCLIC_CODER_FRAMED -- requirements
Module: cyclic_coder_framed

Interface
REQ-001 SHALL have parameter N, default 15; codeword length in bits, 3..255.
REQ-002 SHALL have parameter K, default 11; information length in bits, 1..N-1; R = N-K.
REQ-003 SHALL have parameter GEN, width R+1, default 5'b10011 (x^4+x+1); generator polynomial, bit i = coefficient of x^i.
REQ-004 SHALL require GEN[R]=1 and GEN[0]=1; violation is an elaboration error.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  global advance enable; low freezes all state.
REQ-008 systematic  input  1  mode select: 1 = systematic, 0 = non-systematic; sampled only at frame start.
REQ-009 in  input  1  serial information bit, highest-degree coefficient first.
REQ-010 in_valid  input  1  in carries a bit this cycle.
REQ-011 in_ready  output  1  block accepts in this cycle (combinational from state and enable).
REQ-012 out  output  1  serial codeword bit, registered, c[N-1] first.
REQ-013 out_valid  output  1  out carries a codeword bit, registered.
REQ-014 out_sof  output  1  high with first codeword bit of a frame.
REQ-015 out_eof  output  1  high with last (N-th) codeword bit of a frame.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> DATA -> TAIL -> IDLE, plus a bit counter of width clog2(N+1).
REQ-018 Accept = enable & in_valid & in_ready; in_ready = enable & (state IDLE or DATA).
REQ-019 Accept in IDLE: latch systematic as frame mode, clear R-bit register, process bit 0, go to DATA (K=1: go directly to TAIL).
REQ-020 DATA: each accept processes next bit; after K-th accepted bit go to TAIL.
REQ-021 DATA with no accept (in_valid low) SHALL hold state, counter and register; out_valid low next cycle.
REQ-022 TAIL SHALL last exactly R enabled cycles, in_ready=0, emitting one bit per enabled cycle regardless of in_valid; then go to IDLE.
REQ-023 Each processed/emitted step SHALL drive out and out_valid=1 on the edge of that step (latency one cycle from accepting edge to out_valid).
REQ-024 Systematic: DATA steps output the input bit unchanged and divide through LFSR (feedback = in XOR reg MSB, taps GEN[R-1:0]); TAIL outputs parity register MSB first, shifting in 0.
REQ-025 Systematic codeword SHALL equal m(x)*x^R + (m(x)*x^R mod g(x)).
REQ-026 Non-systematic: step j (0..N-1) output = XOR over k=0..R of GEN[R-k]&u[j-k], u[t] = t-th input bit for 0<=t<K, else 0.
REQ-027 Non-systematic TAIL SHALL insert zeros internally; no user padding bits required.
REQ-028 out_sof high only on step 0 output; out_eof high only on step N-1 output; both 0 when out_valid=0.
REQ-029 Accept in IDLE on the cycle after out_eof SHALL start a new frame with no bubble; back-to-back frames allowed.
REQ-030 systematic changes during a frame SHALL not affect that frame.
REQ-031 enable low SHALL freeze FSM, counter, register and all outputs at current values except out_valid, out_sof, out_eof, which go 0 next edge.

Reset
REQ-032 reset SHALL take priority over enable and accept.
REQ-033 After reset: state IDLE, counter 0, register 0, out=0, out_valid=0, out_sof=0, out_eof=0, busy=0, frame mode=1.
REQ-034 reset mid-frame SHALL abandon the frame; no further bits of it are emitted and next accept starts a fresh frame.

Verification
REQ-035 Defaults, non-systematic, in 10000000001 contiguous -> out 100110000010011, sof on bit 1, eof on bit 15, 15 consecutive valids.
REQ-036 Defaults, systematic, same input -> out 100000000011010 (parity 1010), in_ready low for 4 TAIL cycles.
REQ-037 Systematic, in_valid deasserted 3 cycles after bit 5 -> same codeword as REQ-036, out_valid gaps of exactly 3 cycles, sof/eof unchanged.
REQ-038 Two back-to-back frames, non-systematic then systematic, mode toggled mid-frame 1 -> outputs per REQ-035 then REQ-036, second sof the cycle after first eof.
REQ-039 reset asserted at DATA bit 6 then new all-zero frame -> all outputs 0 after reset, then 15 zero bits with correct sof/eof.
REQ-040 enable low 2 cycles during TAIL -> outputs held, no valid, parity bits resume in order; total codeword per REQ-036.

Source files
------------

// File: rtl/cyclic_coder_framed.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cyclic_coder_framed : serial (N,K) cyclic encoder, systematic or non-systematic, framed output
// Rev 1.0
// ---------------------------------------------------------------------------
module cyclic_coder_framed #(
  parameter int N = 15,
  parameter int K = 11,
  parameter logic [N-K:0] GEN = 5'b10011
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic systematic,
  input  logic in,
  input  logic in_valid,
  output logic in_ready,
  output logic out,
  output logic out_valid,
  output logic out_sof,
  output logic out_eof,
  output logic busy
);

  localparam int R  = N - K;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;
  localparam logic [1:0] S_FIRST = (K == 1) ? S_TAIL : S_DATA;

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_KLAST = CW'(K - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(N - 1);

  generate
    if (N < 3 || N > 255 || K < 1 || K > N - 1) begin : g_bad_nk
      $error("cyclic_coder_framed: N must be 3..255 and K must be 1..N-1");
    end
    if (GEN[R] == 1'b0 || GEN[0] == 1'b0) begin : g_bad_gen
      $error("cyclic_coder_framed: generator needs GEN[R]=1 and GEN[0]=1");
    end
  endgenerate

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [R-1:0]  r_reg;
  logic          r_mode;

  logic [R-1:0]  w_base;
  logic [R-1:0]  w_next;
  logic          w_mode;
  logic          w_u;
  logic          w_fb;
  logic          w_out;
  logic          w_accept;
  logic          w_step;

  assign in_ready = enable & ((r_state == S_IDLE) | (r_state == S_DATA));
  assign busy     = (r_state != S_IDLE);
  assign w_accept = in_valid & in_ready;
  assign w_step   = w_accept | (enable & (r_state == S_TAIL));

  // r_reg is the parity remainder in systematic mode and the input history
  // (u[j-1] in bit 0) in non-systematic mode; a new frame starts from zero.
  always_comb begin
    w_base = (r_state == S_IDLE) ? '0 : r_reg;
    w_mode = (r_state == S_IDLE) ? systematic : r_mode;
    w_u    = (r_state == S_TAIL) ? 1'b0 : in;
    w_fb   = w_u ^ w_base[R-1];
    w_out  = 1'b0;
    w_next = '0;
    if (w_mode) begin
      if (r_state == S_TAIL) begin
        w_out  = w_base[R-1];
        w_next = w_base << 1;
      end else begin
        w_out  = w_u;
        w_next = (w_base << 1) ^ (w_fb ? GEN[R-1:0] : '0);
      end
    end else begin
      w_out = GEN[R] & w_u;
      for (int k = 1; k <= R; k++) begin
        w_out = w_out ^ (GEN[R-k] & w_base[k-1]);
      end
      w_next = (w_base << 1) | R'(w_u);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_reg     <= '0;
      r_mode    <= 1'b1;
      out       <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= w_step;
      out_sof   <= w_step & (r_state == S_IDLE);
      out_eof   <= w_step & (r_cnt == C_LAST);
      if (w_step) begin
        out   <= w_out;
        r_reg <= w_next;
        case (r_state)
          S_IDLE: begin
            r_mode  <= systematic;
            r_cnt   <= C_ONE;
            r_state <= S_FIRST;
          end
          S_DATA: begin
            r_cnt <= r_cnt + C_ONE;
            if (r_cnt == C_KLAST) r_state <= S_TAIL;
          end
          S_TAIL: begin
            if (r_cnt == C_LAST) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cyclic_coder_framed.sv
`default_nettype none
// Testbench for cyclic_coder_framed with the default (15,11) code, g = x^4+x+1.
module tb_cyclic_coder_framed;

  localparam int N = 15;
  localparam int K = 11;

  logic clk = 1'b0;
  logic reset, enable, systematic, in, in_valid;
  logic in_ready, out, out_valid, out_sof, out_eof, busy;

  always #5 clk = ~clk;

  cyclic_coder_framed #(.N(N), .K(K), .GEN(5'b10011)) dut (
    .clk(clk), .reset(reset), .enable(enable), .systematic(systematic),
    .in(in), .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .busy(busy)
  );

  typedef struct {
    logic b;
    logic sof;
    logic eof;
    int   cyc;
  } obs_t;

  typedef struct {
    logic [K-1:0] msg;
    logic         sys;
    logic [N-1:0] cw;
  } vec_t;

  obs_t obs[$];
  int   cyc = 0;
  int   stray = 0;
  int   errors = 0;
  int   checks = 0;

  localparam logic [K-1:0] MSG_A = 11'b10000000001;
  localparam logic [N-1:0] NS_A  = 15'b100110000010011;
  localparam logic [N-1:0] SYS_A = 15'b100000000011010;

  always @(negedge clk) begin
    cyc++;
    if (out_valid) obs.push_back(obs_t'{out, out_sof, out_eof, cyc});
    else if (out_sof || out_eof) stray++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT, expected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [K-1:0] msg, input logic sys, input int gap_after,
                            input int gap_len, input int toggle_at, output int tail_low);
    int n;
    for (int i = 0; i < K; i++) begin
      n = 0;
      while (!in_ready && n < 40) begin tick(); n++; end
      if (!in_ready) fail_timeout("in_ready_wait");
      systematic = (toggle_at >= 0 && i >= toggle_at) ? ~sys : sys;
      in       = msg[K-1-i];
      in_valid = 1'b1;
      tick();
      if (i == gap_after) begin
        in_valid = 1'b0;
        in       = ~in;
        repeat (gap_len) tick();
      end
    end
    in_valid = 1'b0;
    in       = 1'b1;
    tail_low = 0;
    while (!in_ready && tail_low < 40) begin tick(); tail_low++; end
  endtask

  task automatic check_frame(input int start, input logic [N-1:0] exp, input string tag,
                             input bit contiguous, output bit ok);
    int n;
    logic [N-1:0] cw, sofs, eofs;
    n = 0;
    while (obs.size() < start + N && n < 60) begin tick(); n++; end
    ok = (obs.size() >= start + N);
    if (!ok) begin
      fail_timeout({tag, "_collect"});
      return;
    end
    cw = '0; sofs = '0; eofs = '0;
    for (int i = 0; i < N; i++) begin
      cw   = {cw[N-2:0],   obs[start+i].b};
      sofs = {sofs[N-2:0], obs[start+i].sof};
      eofs = {eofs[N-2:0], obs[start+i].eof};
    end
    chk({tag, "_codeword"}, cw, exp);
    chk({tag, "_sof"}, sofs, 15'b100000000000000);
    chk({tag, "_eof"}, eofs, 15'b000000000000001);
    if (contiguous) chk({tag, "_span"}, obs[start+N-1].cyc - obs[start].cyc, N - 1);
  endtask

  vec_t vecs[7];

  initial begin
    int start, start2, tl, nb;
    bit ok;

    vecs[0] = '{MSG_A,          1'b0, NS_A};
    vecs[1] = '{MSG_A,          1'b1, SYS_A};
    vecs[2] = '{11'b00000000000, 1'b0, 15'b000000000000000};
    vecs[3] = '{11'b10000000000, 1'b1, 15'b100000000001001};
    vecs[4] = '{11'b11111111111, 1'b0, 15'b111011111110001};
    vecs[5] = '{11'b00000000001, 1'b1, 15'b000000000010011};
    vecs[6] = '{11'b10000000000, 1'b0, 15'b100110000000000};

    reset = 1'b1; enable = 1'b1; systematic = 1'b1; in = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {out, out_valid, out_sof, out_eof, busy}, 5'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      start = obs.size();
      send_frame(vecs[v].msg, vecs[v].sys, -1, 0, -1, tl);
      chk($sformatf("vec%0d_tail_ready_low", v), tl, 4);
      check_frame(start, vecs[v].cw, $sformatf("vec%0d", v), 1'b1, ok);
    end

    // input stall of 3 cycles after the 5th bit
    start = obs.size();
    send_frame(MSG_A, 1'b1, 4, 3, -1, tl);
    check_frame(start, SYS_A, "stall", 1'b0, ok);
    if (ok) begin
      chk("stall_gap", obs[start+5].cyc - obs[start+4].cyc, 4);
      chk("stall_span", obs[start+N-1].cyc - obs[start].cyc, N - 1 + 3);
    end

    // back-to-back frames, mode input toggled mid-way through the first
    start = obs.size();
    send_frame(MSG_A, 1'b0, -1, 0, 5, tl);
    send_frame(MSG_A, 1'b1, -1, 0, -1, tl);
    check_frame(start, NS_A, "b2b_first", 1'b1, ok);
    check_frame(start + N, SYS_A, "b2b_second", 1'b1, ok);
    if (ok) chk("b2b_no_bubble", obs[start+N].cyc - obs[start+N-1].cyc, 1);

    // reset in the middle of a frame
    start = obs.size();
    systematic = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in = MSG_A[K-1-i]; in_valid = 1'b1; tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("midrst_outputs", {out, out_valid, out_sof, out_eof, busy}, 5'b0);
    reset = 1'b0;
    nb = obs.size();
    repeat (5) tick();
    chk("midrst_partial_bits", nb - start, 6);
    chk("midrst_no_more_bits", obs.size(), nb);
    start2 = obs.size();
    send_frame(11'b0, 1'b0, -1, 0, -1, tl);
    check_frame(start2, 15'b0, "post_reset", 1'b1, ok);

    // enable dropped for 2 cycles during the parity tail
    start = obs.size();
    systematic = 1'b1;
    for (int i = 0; i < K; i++) begin
      in = MSG_A[K-1-i]; in_valid = 1'b1; tick();
    end
    in_valid = 1'b0;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("enlow%0d_flags", i), {out_valid, out_sof, out_eof}, 3'b000);
      chk($sformatf("enlow%0d_out_held", i), out, 1'b1);
      chk($sformatf("enlow%0d_busy_ready", i), {busy, in_ready}, 2'b10);
    end
    enable = 1'b1;
    nb = 0;
    while (!in_ready && nb < 40) begin tick(); nb++; end
    check_frame(start, SYS_A, "enlow", 1'b0, ok);
    if (ok) chk("enlow_span", obs[start+N-1].cyc - obs[start].cyc, N - 1 + 2);

    chk("stray_sof_eof", stray, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
